neuron_train_ctrl: RTL and testbench
====================================

NEURON_TRAIN_CTRL -- requirements
Module: neuron_train_ctrl

Interface
REQ-001 Parameter NUM_INPUTS, default 2: number of weighted input channels (1..16).
REQ-002 Parameter IDX_W, default 4: width of w_idx, SHALL satisfy 2**IDX_W >= NUM_INPUTS.
REQ-003 Parameter SAMPLE_W, default 8: width of the per-epoch sample counter.
REQ-004 Parameter EPOCH_W, default 8: width of the epoch counter.
REQ-005 Parameter MAX_EPOCHS, default 100: epoch limit, used only under NEURON_EPOCH_LIMIT_EN.
REQ-006 clk  in  1  single clock, rising edge.
REQ-007 rst  in  1  asynchronous reset, active-low.
REQ-008 start  in  1  begin training; sampled in IDLE only.
REQ-009 data_ready  in  1  datapath has a sample (x, t) valid.
REQ-010 last_sample  in  1  current sample is the final one of the set.
REQ-011 y_eq_t  in  1  computed output equals target.
REQ-012 done  out  1  high in IDLE.
REQ-013 busy  out  1  high in every state except IDLE.
REQ-014 req  out  1  sample request, high in REQ.
REQ-015 clr  out  1  clear datapath weights/bias, high in INIT.
REQ-016 ld_x  out  1  load all x channels and t, high in GET.
REQ-017 ld_y  out  1  latch neuron output, high in CALC.
REQ-018 ld_w  out  1  load weight w_idx, high in UPD_W.
REQ-019 w_idx  out  IDX_W  weight channel being updated.
REQ-020 ld_b  out  1  load bias, high in UPD_B.
REQ-021 sample_cnt  out  SAMPLE_W  samples taken this epoch.
REQ-022 epoch_cnt  out  EPOCH_W  completed epochs.
REQ-023 converged  out  1  last run ended on an error-free epoch.
REQ-024 timeout  out  1  last run ended on epoch limit.

Function
REQ-025 States SHALL be IDLE, INIT, REQ, GET, CALC, UPD_W, UPD_B, EPOCH_END; all strobes Moore-decoded from state, default 0.
REQ-026 Transitions: IDLE->INIT on start; INIT->REQ; REQ->GET when data_ready else hold; GET->CALC; CALC->UPD_W if !y_eq_t, else EPOCH_END if last_sample, else REQ.
REQ-027 UPD_W SHALL last exactly NUM_INPUTS cycles, w_idx 0..NUM_INPUTS-1, one per cycle, then UPD_B for one cycle.
REQ-028 UPD_B->EPOCH_END if last_sample (registered in GET), else REQ.
REQ-029 An internal err_seen flag SHALL set on any UPD_B cycle and clear in INIT and on epoch restart.
REQ-030 EPOCH_END: epoch_cnt increments; if err_seen ->REQ with sample_cnt=0, err_seen=0; else ->IDLE with converged=1.
REQ-031 sample_cnt SHALL increment in GET, saturate at all-ones, clear in INIT and epoch restart.
REQ-032 epoch_cnt SHALL saturate at all-ones; clears in INIT.
REQ-033 converged and timeout SHALL clear in INIT and hold their values through IDLE.
REQ-034 start asserted while busy SHALL be ignored.
REQ-035 last_sample SHALL be captured in GET; changes in other states have no effect.
REQ-036 w_idx SHALL be 0 outside UPD_W.

Reset
REQ-037 rst low SHALL force IDLE immediately and zero all counters, w_idx, err_seen, converged, timeout; done=1, all other outputs 0.
REQ-038 Reset mid-training SHALL abandon the run with no further strobes; restart requires start.

Configuration
REQ-039 Macro NEURON_EPOCH_LIMIT_EN defined: in EPOCH_END with err_seen and epoch_cnt+1 == MAX_EPOCHS, SHALL go to IDLE with timeout=1, converged=0.
REQ-040 Macro undefined: no epoch limit, timeout tied 0, training repeats until an error-free epoch.

Verification
REQ-041 NUM_INPUTS=3, 2 samples, y_eq_t=1 always -> one epoch, converged=1, epoch_cnt=1, no ld_w pulses.
REQ-042 NUM_INPUTS=3, y_eq_t=0 on sample 1 -> ld_w for 3 cycles with w_idx 0,1,2, then 1-cycle ld_b.
REQ-043 Errors in epoch 1, none in epoch 2 -> sample_cnt resets, epoch_cnt=2, converged=1.
REQ-044 NEURON_EPOCH_LIMIT_EN, MAX_EPOCHS=4, y_eq_t=0 always -> IDLE after epoch 4, timeout=1, epoch_cnt=4.
REQ-045 data_ready held low 5 cycles in REQ -> req stays high, no ld_x until data_ready.
REQ-046 rst low during UPD_W -> outputs zero, done=1 same cycle; start afterwards reruns from INIT.

Source files
------------

// File: rtl/neuron_train_ctrl.sv
// Training-sequence controller for a single perceptron-style neuron datapath.
// Optional epoch limit enabled by defining NEURON_EPOCH_LIMIT_EN.
module neuron_train_ctrl #(
    parameter int NUM_INPUTS = 2,
    parameter int IDX_W      = 4,
    parameter int SAMPLE_W   = 8,
    parameter int EPOCH_W    = 8,
    parameter int MAX_EPOCHS = 100
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                data_ready,
    input  logic                last_sample,
    input  logic                y_eq_t,
    output logic                done,
    output logic                busy,
    output logic                req,
    output logic                clr,
    output logic                ld_x,
    output logic                ld_y,
    output logic                ld_w,
    output logic [IDX_W-1:0]    w_idx,
    output logic                ld_b,
    output logic [SAMPLE_W-1:0] sample_cnt,
    output logic [EPOCH_W-1:0]  epoch_cnt,
    output logic                converged,
    output logic                timeout
);

    typedef enum logic [2:0] {
        IDLE, INIT, REQ, GET, CALC, UPD_W, UPD_B, EPOCH_END
    } state_t;

`ifdef NEURON_EPOCH_LIMIT_EN
    localparam bit LIMIT_EN = 1'b1;
`else
    localparam bit LIMIT_EN = 1'b0;
`endif

    localparam logic [IDX_W-1:0] W_LAST      = IDX_W'(NUM_INPUTS - 1);
    localparam logic [EPOCH_W:0] EPOCH_LIMIT = (EPOCH_W + 1)'(MAX_EPOCHS);

    state_t state;
    state_t nxt;
    logic   last_q;
    logic   err_seen;
    logic   limit_hit;

    // Compared one bit wider so a limit equal to 2**EPOCH_W is still reachable.
    assign limit_hit = LIMIT_EN && (({1'b0, epoch_cnt} + 1'b1) == EPOCH_LIMIT);

    always_comb begin
        // NOTE: default assignment first keeps this block free of inferred latches.
        nxt = state;
        case (state)
            IDLE:      if (start) nxt = INIT;
            INIT:      nxt = REQ;
            REQ:       if (data_ready) nxt = GET;
            GET:       nxt = CALC;
            CALC: begin
                if (!y_eq_t)     nxt = UPD_W;
                else if (last_q) nxt = EPOCH_END;
                else             nxt = REQ;
            end
            UPD_W:     if (w_idx == W_LAST) nxt = UPD_B;
            UPD_B:     nxt = last_q ? EPOCH_END : REQ;
            EPOCH_END: nxt = (err_seen && !limit_hit) ? REQ : IDLE;
            default:   nxt = IDLE;
        endcase
    end

    // Strobes are registered from the next state, so they equal a Moore decode
    // of the current state without a combinational path to the outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            done       <= 1'b1;
            busy       <= 1'b0;
            req        <= 1'b0;
            clr        <= 1'b0;
            ld_x       <= 1'b0;
            ld_y       <= 1'b0;
            ld_w       <= 1'b0;
            ld_b       <= 1'b0;
            w_idx      <= '0;
            sample_cnt <= '0;
            epoch_cnt  <= '0;
            converged  <= 1'b0;
            timeout    <= 1'b0;
            err_seen   <= 1'b0;
            last_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register sees pre-edge values.
            state <= nxt;
            done  <= (nxt == IDLE);
            busy  <= (nxt != IDLE);
            req   <= (nxt == REQ);
            clr   <= (nxt == INIT);
            ld_x  <= (nxt == GET);
            ld_y  <= (nxt == CALC);
            ld_w  <= (nxt == UPD_W);
            ld_b  <= (nxt == UPD_B);
            w_idx <= (state == UPD_W && nxt == UPD_W) ? w_idx + 1'b1 : '0;

            case (state)
                IDLE: begin
                    if (start) begin
                        sample_cnt <= '0;
                        epoch_cnt  <= '0;
                        converged  <= 1'b0;
                        timeout    <= 1'b0;
                        err_seen   <= 1'b0;
                        last_q     <= 1'b0;
                    end
                end
                GET: begin
                    last_q <= last_sample;
                    if (sample_cnt != '1) sample_cnt <= sample_cnt + 1'b1;
                end
                UPD_B: err_seen <= 1'b1;
                EPOCH_END: begin
                    if (epoch_cnt != '1) epoch_cnt <= epoch_cnt + 1'b1;
                    if (!err_seen) begin
                        converged <= 1'b1;
                    end else if (limit_hit) begin
                        timeout   <= 1'b1;
                        converged <= 1'b0;
                    end else begin
                        sample_cnt <= '0;
                        err_seen   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_neuron_train_ctrl.sv
// Directed bench for neuron_train_ctrl: strobe scoreboard plus status checks.
module tb_neuron_train_ctrl;

    localparam int NI = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       data_ready = 1'b0;
    logic       last_sample = 1'b0;
    logic       y_eq_t = 1'b0;
    logic       done, busy, req, clr, ld_x, ld_y, ld_w, ld_b;
    logic [3:0] w_idx;
    logic [1:0] sample_cnt;
    logic [7:0] epoch_cnt;
    logic       converged, timeout;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] exp_q[$];

    localparam logic [7:0] EV_CLR  = 8'h10;
    localparam logic [7:0] EV_LDX  = 8'h20;
    localparam logic [7:0] EV_LDY  = 8'h30;
    localparam logic [7:0] EV_LDW  = 8'h40;
    localparam logic [7:0] EV_LDB  = 8'h50;
    localparam logic [7:0] EV_NONE = 8'hFF;

    neuron_train_ctrl #(
        .NUM_INPUTS(NI), .IDX_W(4), .SAMPLE_W(2), .EPOCH_W(8), .MAX_EPOCHS(4)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .data_ready(data_ready),
        .last_sample(last_sample), .y_eq_t(y_eq_t), .done(done), .busy(busy),
        .req(req), .clr(clr), .ld_x(ld_x), .ld_y(ld_y), .ld_w(ld_w),
        .w_idx(w_idx), .ld_b(ld_b), .sample_cnt(sample_cnt),
        .epoch_cnt(epoch_cnt), .converged(converged), .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Every strobe pulse is matched against the next expected event.
    always @(negedge clk) begin : mon
        logic [7:0] ev;
        logic       hit;
        hit = 1'b1;
        ev  = EV_NONE;
        if (clr)       ev = EV_CLR;
        else if (ld_x) ev = EV_LDX;
        else if (ld_y) ev = EV_LDY;
        else if (ld_w) ev = EV_LDW | {4'h0, w_idx};
        else if (ld_b) ev = EV_LDB;
        else           hit = 1'b0;
        if (hit) begin
            if (exp_q.size() == 0) check("strobe_unexpected", ev, EV_NONE);
            else                   check("strobe_seq", ev, exp_q.pop_front());
        end
        if (!ld_w) check("w_idx_idle", w_idx, 0);
    end

    task automatic wait_req();
        int n = 0;
        while (req !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("req_reached", req, 1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (done !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("idle_reached", done, 1);
    endtask

    task automatic start_run();
        exp_q.push_back(EV_CLR);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("init_busy", busy, 1);
        check("init_conv_clr", converged, 0);
        check("init_tmo_clr", timeout, 0);
        check("init_epoch_clr", epoch_cnt, 0);
        check("init_sample_clr", sample_cnt, 0);
    endtask

    task automatic do_sample(input bit ok, input bit last, input int hold);
        wait_req();
        repeat (hold) begin
            @(negedge clk);
            check("req_held", req, 1);
        end
        exp_q.push_back(EV_LDX);
        exp_q.push_back(EV_LDY);
        if (!ok) begin
            for (int i = 0; i < NI; i++) exp_q.push_back(EV_LDW | 8'(i));
            exp_q.push_back(EV_LDB);
        end
        data_ready  = 1'b1;
        last_sample = last;
        y_eq_t      = ok;
        @(negedge clk);
        data_ready  = 1'b0;
        @(negedge clk);
        last_sample = ~last;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        repeat (2) @(negedge clk);
        check("rst_done", done, 1);
        check("rst_busy", busy, 0);
        check("rst_req", req, 0);
        check("rst_clr", clr, 0);
        check("rst_ld_x", ld_x, 0);
        check("rst_ld_w", ld_w, 0);
        check("rst_sample", sample_cnt, 0);
        check("rst_epoch", epoch_cnt, 0);
        check("rst_conv", converged, 0);
        check("rst_tmo", timeout, 0);
        rst = 1'b1;
        @(negedge clk);

        // Clean single epoch: no weight updates.
        start_run();
        do_sample(1'b1, 1'b0, 0);
        do_sample(1'b1, 1'b1, 0);
        wait_idle();
        check("t1_conv", converged, 1);
        check("t1_epoch", epoch_cnt, 1);
        check("t1_sample", sample_cnt, 2);
        check("t1_tmo", timeout, 0);
        repeat (3) @(negedge clk);
        check("t1_conv_hold", converged, 1);

        // Error in epoch 1 with a stalled request and start held while busy.
        start_run();
        start = 1'b1;
        do_sample(1'b0, 1'b0, 5);
        start = 1'b0;
        do_sample(1'b1, 1'b1, 0);
        wait_req();
        check("t2_restart_sample", sample_cnt, 0);
        check("t2_epoch1", epoch_cnt, 1);
        check("t2_not_conv", converged, 0);
        do_sample(1'b1, 1'b0, 0);
        do_sample(1'b1, 1'b1, 0);
        wait_idle();
        check("t2_conv", converged, 1);
        check("t2_epoch", epoch_cnt, 2);
        check("t2_sample", sample_cnt, 2);

        // Sample counter saturates at 3 with a 2-bit counter.
        start_run();
        for (int i = 0; i < 5; i++) do_sample(1'b1, i == 4, 0);
        wait_idle();
        check("t3_sample_sat", sample_cnt, 3);
        check("t3_epoch", epoch_cnt, 1);
        check("t3_conv", converged, 1);

        // Reset in the middle of the weight update.
        start_run();
        wait_req();
        exp_q.push_back(EV_LDX);
        exp_q.push_back(EV_LDY);
        exp_q.push_back(EV_LDW | 8'd0);
        exp_q.push_back(EV_LDW | 8'd1);
        data_ready  = 1'b1;
        last_sample = 1'b0;
        y_eq_t      = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (!(ld_w === 1'b1 && w_idx == 4'd1) && n < 50);
        check("t4_upd_w_reached", ld_w, 1);
        data_ready = 1'b0;
        rst = 1'b0;
        #1;
        check("t4_done", done, 1);
        check("t4_busy", busy, 0);
        check("t4_ld_w", ld_w, 0);
        check("t4_ld_b", ld_b, 0);
        check("t4_req", req, 0);
        check("t4_w_idx", w_idx, 0);
        check("t4_sample", sample_cnt, 0);
        check("t4_epoch", epoch_cnt, 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        check("t4_stay_idle", done, 1);
        check("t4_queue", exp_q.size(), 0);
        start_run();
        do_sample(1'b1, 1'b1, 0);
        wait_idle();
        check("t4_rerun_conv", converged, 1);
        check("t4_rerun_epoch", epoch_cnt, 1);

`ifdef NEURON_EPOCH_LIMIT_EN
        // Persistent errors stop at the epoch limit.
        start_run();
        repeat (4) do_sample(1'b0, 1'b1, 0);
        wait_idle();
        check("t5_tmo", timeout, 1);
        check("t5_conv", converged, 0);
        check("t5_epoch", epoch_cnt, 4);
`else
        // Without the limit, training keeps going past 4 error epochs.
        start_run();
        repeat (5) do_sample(1'b0, 1'b1, 0);
        do_sample(1'b1, 1'b1, 0);
        wait_idle();
        check("t5_tmo", timeout, 0);
        check("t5_conv", converged, 1);
        check("t5_epoch", epoch_cnt, 6);
`endif

        repeat (2) @(negedge clk);
        check("final_queue", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
